instruction_issuer: RTL

- Producer end of the 19-bit instruction interface consumed by the jericalla datapath. It drives the datapath's `instruction` input each cycle.
- Holds a small program memory, loaded through a write port while idle, and steps a program counter through it after `start`.
- Inserts NOP bubbles on read-after-write hazards against instructions still in the datapath pipeline.
- Stops on a HALT opcode or at the end of memory.

---
 rtl/jericalla_pkg.sv | 16 +
 rtl/hazard_window.sv | 36 +++
 rtl/instruction_issuer.sv | 86 ++++++++
 3 files changed

// File: rtl/jericalla_pkg.sv
// jericalla_pkg: opcodes, instruction field layout and issuer state encoding shared by the jericalla issuer.
package jericalla_pkg;
  localparam int OP_W = 4;
  localparam int REG_W = 5;
  localparam int OP_LSB = 15;
  localparam int WA_LSB = 10;
  localparam int RA1_LSB = 5;
  localparam int RA2_LSB = 0;
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_STORE = 4'h1;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;
  function automatic logic writes_reg(input logic [OP_W-1:0] op);
    return !(op inside {OP_NOP, OP_STORE, OP_HALT});
  endfunction
endpackage

// File: rtl/hazard_window.sv
// hazard_window: shift register of recently issued {writes, wa} entries with a combinational RAW hazard check.
module hazard_window
  import jericalla_pkg::*;
#(
  parameter int HAZARD_WINDOW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             in_writes,
  input  logic [REG_W-1:0] in_wa,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic             hazard
);
  logic [HAZARD_WINDOW-1:0] wr;
  logic [REG_W-1:0] wa [HAZARD_WINDOW];
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr <= '0;
    end else if (shift) begin
      for (int i = HAZARD_WINDOW - 1; i > 0; i--) begin
        wr[i] <= wr[i-1];
        wa[i] <= wa[i-1];
      end
      wr[0] <= in_writes;
      wa[0] <= in_wa;
    end
  end
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_WINDOW; i++)
      hazard = hazard || (wr[i] && (wa[i] == ra1 || wa[i] == ra2));
  end
endmodule

// File: rtl/instruction_issuer.sv
// instruction_issuer: program memory + PC sequencer feeding the jericalla datapath; RAW interlock built only with INSTR_ISSUER_HAZARD_STALL_EN.
module instruction_issuer
  import jericalla_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5,
  parameter int INSTR_W = 19,
  parameter int HAZARD_WINDOW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instruction,
  output logic               issue_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);
  logic [INSTR_W-1:0] mem [DEPTH];
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [INSTR_W-1:0] word, instr_nx;
  logic [OP_W-1:0] op;
  logic valid_nx, hazard, last, start_run;
  assign word = mem[pc];
  assign op = word[OP_LSB +: OP_W];
  assign last = pc == ADDR_W'(DEPTH - 1);
  assign busy = state == RUN || state == STALL;
  assign done = state == DONE;
  assign start_run = !busy && start && !prog_we;
`ifdef INSTR_ISSUER_HAZARD_STALL_EN
  // Window is cleared on start so a rerun never stalls on words from the previous run.
  hazard_window #(.HAZARD_WINDOW(HAZARD_WINDOW)) u_window (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_run),
    .shift    (busy),
    .in_writes(valid_nx && writes_reg(op)),
    .in_wa    (word[WA_LSB +: REG_W]),
    .ra1      (word[RA1_LSB +: REG_W]),
    .ra2      (word[RA2_LSB +: REG_W]),
    .hazard   (hazard)
  );
`else
  logic unused_window;
  assign unused_window = HAZARD_WINDOW != 0;
  assign hazard = 1'b0;
`endif
  always_ff @(posedge clk)
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    instr_nx = '0;
    valid_nx = 1'b0;
    if (start_run) begin
      state_nx = RUN;
      pc_nx = '0;
    end else if (busy) begin
      if (op == OP_HALT) state_nx = DONE;
      else if (hazard) state_nx = STALL;
      else begin
        instr_nx = word;
        valid_nx = 1'b1;
        state_nx = last ? DONE : RUN;
        pc_nx = last ? pc : pc + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      instruction <= '0;
      issue_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      instruction <= instr_nx;
      issue_valid <= valid_nx;
    end
  end
endmodule
